cdb_arbiter: RTL

Common-data-bus arbiter between the ALU result port and the LSB result port (load data or store-done). It buffers each source in a small FIFO and grants one result per cycle onto a registered CDB that feeds RS, LSB and ROB. It replaces the current shared-wire broadcast, so simultaneous ALU and LSB completions no longer collide. It asserts backpressure toward RS dispatch and the LSB, and drops all pending results on a ROB misprediction flush.

---
 rtl/cdb_arbiter_pkg.sv | 28 ++
 rtl/cdb_fifo.sv | 65 ++++++
 rtl/cdb_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common-data-bus arbiter: source encodings,
// ROB tag sizing and the round-robin pick helper.
package cdb_arbiter_pkg;

   // ROB holds 2**ROB_SZ_LOG entries; tags carry one extra bit.
   localparam int ROB_SZ_LOG = 4;

   // Source identifiers as they appear on cdb_src and in last_grant.
   localparam logic CDB_SRC_ALU = 1'b0;
   localparam logic CDB_SRC_LSB = 1'b1;

   // Round-robin pick between the two candidates. A lone candidate always
   // wins; on a tie the source that was not granted last wins. The result
   // is only meaningful when at least one candidate is present.
   function automatic logic pick_src(
      input logic alu_v,
      input logic lsb_v,
      input logic last_grant
   );
      logic src;
      src = CDB_SRC_LSB;
      if (alu_v && (!lsb_v || last_grant == CDB_SRC_LSB)) begin
         src = CDB_SRC_ALU;
      end
      return src;
   endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Small result FIFO used in front of each CDB source. Head is read
// combinationally so the arbiter can compare candidates in the same cycle.
// Pushing into a full FIFO without a simultaneous pop drops the entry.
module cdb_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] CAP = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr_reg;
   logic [PW-1:0]    wr_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             do_pop;
   logic             do_push;

   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign dout    = mem[rd_ptr_reg];
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot the push needs.
   assign do_push = push && ((count_reg != CAP) || do_pop);

   // Pointer and occupancy bookkeeping; flush empties without touching storage.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Entry storage, written at the tail on every accepted push.
   always_ff @(posedge clk) begin
      if (do_push && !flush && !rst) begin
         mem[wr_ptr_reg] <= din;
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: buffers ALU and LSB completions, grants one
// result per cycle onto a registered CDB with round-robin fairness, raises
// backpressure to the producers and drops everything on a flush.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int ROB_W     = ROB_SZ_LOG + 1,
   parameter int ALU_DEPTH = 4,
   parameter int LSB_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             alu_flg,
   input  logic [ROB_W-1:0] alu_rd,
   input  logic [31:0]      alu_res,
   input  logic [31:0]      alu_res2,
   input  logic             lsb_flg,
   input  logic             lsb_str,
   input  logic [ROB_W-1:0] lsb_rd,
   input  logic [31:0]      lsb_res,
   input  logic             flush,
   output logic             cdb_flg,
   output logic             cdb_src,
   output logic             cdb_str,
   output logic [ROB_W-1:0] cdb_rd,
   output logic [31:0]      cdb_res,
   output logic [31:0]      cdb_res2,
   output logic             alu_full,
   output logic             lsb_full,
   output logic             ovf
);

   localparam int ALU_W  = ROB_W + 64;
   localparam int LSB_W  = 1 + ROB_W + 32;
   localparam int ALU_CW = $clog2(ALU_DEPTH) + 1;
   localparam int LSB_CW = $clog2(LSB_DEPTH) + 1;
   localparam logic [ALU_CW-1:0] ALU_FULL_AT = ALU_CW'(ALU_DEPTH - 1);
   localparam logic [LSB_CW-1:0] LSB_FULL_AT = LSB_CW'(LSB_DEPTH - 1);
   localparam logic [ALU_CW-1:0] ALU_CAP     = ALU_CW'(ALU_DEPTH);
   localparam logic [LSB_CW-1:0] LSB_CAP     = LSB_CW'(LSB_DEPTH);

   // FIFO interface
   logic [ALU_W-1:0]  alu_in, alu_head, alu_cand;
   logic [LSB_W-1:0]  lsb_in, lsb_head, lsb_cand;
   logic              alu_empty, lsb_empty;
   logic [ALU_CW-1:0] alu_count;
   logic [LSB_CW-1:0] lsb_count;
   logic              alu_push, alu_pop, lsb_push, lsb_pop;
   logic              fifo_flush;

   // Arbitration
   logic              active;
   logic              alu_cand_valid, lsb_cand_valid;
   logic              grant_src;
   logic              grant_alu, grant_lsb;
   logic              ovf_hit;

   // Registered state
   logic              last_grant_reg;
   logic              cdb_flg_reg, cdb_src_reg, cdb_str_reg;
   logic [ROB_W-1:0]  cdb_rd_reg;
   logic [31:0]       cdb_res_reg, cdb_res2_reg;
   logic              ovf_reg;

   assign alu_in = {alu_rd, alu_res, alu_res2};
   assign lsb_in = {lsb_str, lsb_rd, lsb_res};

   // rdy low freezes everything, including a pending flush.
   assign active     = rdy && !flush;
   assign fifo_flush = rdy && flush;

   // Queued entries always go first so inputs never overtake them.
   assign alu_cand_valid = !alu_empty || alu_flg;
   assign lsb_cand_valid = !lsb_empty || lsb_flg;
   assign alu_cand       = alu_empty ? alu_in : alu_head;
   assign lsb_cand       = lsb_empty ? lsb_in : lsb_head;

   assign grant_src = pick_src(alu_cand_valid, lsb_cand_valid, last_grant_reg);
   assign grant_alu = active && alu_cand_valid && (grant_src == CDB_SRC_ALU);
   assign grant_lsb = active && lsb_cand_valid && (grant_src == CDB_SRC_LSB);

   // A winning head is popped; a winning bypassed input never enters the FIFO.
   assign alu_pop  = grant_alu && !alu_empty;
   assign lsb_pop  = grant_lsb && !lsb_empty;
   assign alu_push = active && alu_flg && !(grant_alu && alu_empty);
   assign lsb_push = active && lsb_flg && !(grant_lsb && lsb_empty);

   // Same drop condition the FIFO applies internally.
   assign ovf_hit = (alu_push && !alu_pop && (alu_count == ALU_CAP)) ||
                    (lsb_push && !lsb_pop && (lsb_count == LSB_CAP));

   // One slot of slack is kept for the entry already in flight.
   assign alu_full = (alu_count >= ALU_FULL_AT);
   assign lsb_full = (lsb_count >= LSB_FULL_AT);

   cdb_fifo #(
      .WIDTH (ALU_W),
      .DEPTH (ALU_DEPTH)
   ) u_alu_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (fifo_flush),
      .push  (alu_push),
      .pop   (alu_pop),
      .din   (alu_in),
      .dout  (alu_head),
      .empty (alu_empty),
      .count (alu_count)
   );

   cdb_fifo #(
      .WIDTH (LSB_W),
      .DEPTH (LSB_DEPTH)
   ) u_lsb_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (fifo_flush),
      .push  (lsb_push),
      .pop   (lsb_pop),
      .din   (lsb_in),
      .dout  (lsb_head),
      .empty (lsb_empty),
      .count (lsb_count)
   );

   // CDB output registers, round-robin state and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         cdb_flg_reg    <= 1'b0;
         cdb_src_reg    <= 1'b0;
         cdb_str_reg    <= 1'b0;
         cdb_rd_reg     <= '0;
         cdb_res_reg    <= '0;
         cdb_res2_reg   <= '0;
         last_grant_reg <= CDB_SRC_LSB;
         ovf_reg        <= 1'b0;
      end else if (rdy) begin
         if (grant_alu) begin
            cdb_flg_reg  <= 1'b1;
            cdb_src_reg  <= CDB_SRC_ALU;
            cdb_str_reg  <= 1'b0;
            cdb_rd_reg   <= alu_cand[ALU_W-1 -: ROB_W];
            cdb_res_reg  <= alu_cand[63:32];
            cdb_res2_reg <= alu_cand[31:0];
         end else if (grant_lsb) begin
            cdb_flg_reg  <= 1'b1;
            cdb_src_reg  <= CDB_SRC_LSB;
            cdb_str_reg  <= lsb_cand[LSB_W-1];
            cdb_rd_reg   <= lsb_cand[LSB_W-2 -: ROB_W];
            cdb_res_reg  <= lsb_cand[31:0];
            cdb_res2_reg <= '0;
         end else begin
            // Data registers keep stale values; only the valid bit drops.
            cdb_flg_reg  <= 1'b0;
         end
         if (grant_alu || grant_lsb) begin
            last_grant_reg <= grant_src;
         end
         if (ovf_hit) begin
            ovf_reg <= 1'b1;
         end
      end
   end

   assign cdb_flg  = cdb_flg_reg;
   assign cdb_src  = cdb_src_reg;
   assign cdb_str  = cdb_str_reg;
   assign cdb_rd   = cdb_rd_reg;
   assign cdb_res  = cdb_res_reg;
   assign cdb_res2 = cdb_res2_reg;
   assign ovf      = ovf_reg;

endmodule
